// File: rtl/ps2_pkg.sv
// Shared types, error codes and timing helpers for the PS/2 host paths.
// Cycle counts are derived from the system clock frequency at elaboration.
package ps2_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INHIBIT,
        ST_REQ,
        ST_SEND,
        ST_ACK,
        ST_WAIT_IDLE,
        ST_FAIL
    } ps2_tx_state_t;

    localparam logic [1:0] ERR_NONE  = 2'b00;
    localparam logic [1:0] ERR_FIRST = 2'b01;
    localparam logic [1:0] ERR_BIT   = 2'b10;
    localparam logic [1:0] ERR_NACK  = 2'b11;

    // Falls that present data, parity and stop; the next fall is the ack slot.
    localparam logic [3:0] LAST_BIT_FALL = 4'd10;

    function automatic int us_to_cycles(input int clk_hz, input int us);
        return (clk_hz / 1_000_000) * us;
    endfunction

    function automatic int timeout_width(input int clk_hz);
        return $clog2(clk_hz / 1000 * 15) + 1;
    endfunction

    function automatic logic odd_parity(input logic [7:0] data);
        return ~^data;
    endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-stage synchronizer for the PS/2 clock and data pins plus a falling-edge
// detector on the synchronized clock; shared by the transmit and receive paths.
module ps2_line_sync (
    input  logic clk,
    input  logic rst,
    input  logic ps2_clk_in,
    input  logic ps2_data_in,
    output logic clk_sync,
    output logic data_sync,
    output logic clk_fall
);

    logic [1:0] pin_raw;
    logic [1:0] pin_sync;
    logic       clk_prev_reg;

    assign pin_raw = {ps2_data_in, ps2_clk_in};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_sync
            logic [1:0] meta_reg;

            // Reset to the idle-high bus level so no false edge follows reset.
            always_ff @(posedge clk) begin
                if (rst) begin
                    meta_reg <= 2'b11;
                end else begin
                    meta_reg <= {meta_reg[0], pin_raw[gi]};
                end
            end

            assign pin_sync[gi] = meta_reg[1];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            clk_prev_reg <= 1'b1;
        end else begin
            clk_prev_reg <= pin_sync[0];
        end
    end

    assign clk_sync  = pin_sync[0];
    assign data_sync = pin_sync[1];
    assign clk_fall  = clk_prev_reg & ~pin_sync[0];

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 command transmitter: inhibit, request-to-send, shift out
// data/parity/stop on device clock falls, then check the device ack.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int CLK_HZ        = 25_175_000,
    parameter int INHIBIT_US    = 100,
    parameter int FIRST_EDGE_US = 15_000,
    parameter int BIT_EDGE_US   = 2_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] tx_data,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [1:0] err_code
);

    localparam int INHIBIT_CYC    = us_to_cycles(CLK_HZ, INHIBIT_US);
    localparam int FIRST_EDGE_CYC = us_to_cycles(CLK_HZ, FIRST_EDGE_US);
    localparam int BIT_EDGE_CYC   = us_to_cycles(CLK_HZ, BIT_EDGE_US);
    localparam int TMO_W          = timeout_width(CLK_HZ);
    localparam int INH_W          = $clog2(INHIBIT_CYC) + 1;
    localparam int CNT_W          = (TMO_W > INH_W) ? TMO_W : INH_W;

    // Counters run down to zero, so each load is one less than the duration.
    localparam logic [CNT_W-1:0] INHIBIT_LOAD = CNT_W'(INHIBIT_CYC - 1);
    localparam logic [CNT_W-1:0] FIRST_LOAD   = CNT_W'(FIRST_EDGE_CYC - 1);
    localparam logic [CNT_W-1:0] BIT_LOAD     = CNT_W'(BIT_EDGE_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

    logic clk_sync;
    logic data_sync;
    logic clk_fall;

    ps2_line_sync u_line_sync (
        .clk         (clk),
        .rst         (rst),
        .ps2_clk_in  (ps2_clk_in),
        .ps2_data_in (ps2_data_in),
        .clk_sync    (clk_sync),
        .data_sync   (data_sync),
        .clk_fall    (clk_fall)
    );

    ps2_tx_state_t    state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [9:0]       shift_reg, shift_next;
    logic [3:0]       bit_cnt_reg, bit_cnt_next;
    logic             clk_oe_reg, clk_oe_next;
    logic             data_oe_reg, data_oe_next;
    logic             busy_reg, busy_next;
    logic             done_reg, done_next;
    logic             err_reg, err_next;
    logic [1:0]       err_code_reg, err_code_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= ST_IDLE;
            cnt_reg      <= '0;
            shift_reg    <= '0;
            bit_cnt_reg  <= '0;
            clk_oe_reg   <= 1'b0;
            data_oe_reg  <= 1'b0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
            err_reg      <= 1'b0;
            err_code_reg <= ERR_NONE;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            shift_reg    <= shift_next;
            bit_cnt_reg  <= bit_cnt_next;
            clk_oe_reg   <= clk_oe_next;
            data_oe_reg  <= data_oe_next;
            busy_reg     <= busy_next;
            done_reg     <= done_next;
            err_reg      <= err_next;
            err_code_reg <= err_code_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        shift_next    = shift_reg;
        bit_cnt_next  = bit_cnt_reg;
        clk_oe_next   = clk_oe_reg;
        data_oe_next  = data_oe_reg;
        busy_next     = busy_reg;
        done_next     = 1'b0;
        err_next      = 1'b0;
        err_code_next = err_code_reg;

        case (state_reg)
            ST_IDLE: begin
                clk_oe_next  = 1'b0;
                data_oe_next = 1'b0;
                if (start) begin
                    shift_next    = {1'b1, odd_parity(tx_data), tx_data};
                    bit_cnt_next  = '0;
                    cnt_next      = INHIBIT_LOAD;
                    busy_next     = 1'b1;
                    clk_oe_next   = 1'b1;
                    err_code_next = ERR_NONE;
                    state_next    = ST_INHIBIT;
                end
            end

            ST_INHIBIT: begin
                // Start bit goes out one cycle before the inhibit period ends.
                if (cnt_reg == CNT_ONE) begin
                    data_oe_next = 1'b1;
                end
                if (cnt_reg == '0) begin
                    data_oe_next = 1'b1;
                    state_next   = ST_REQ;
                end else begin
                    cnt_next = cnt_reg - CNT_ONE;
                end
            end

            ST_REQ: begin
                clk_oe_next = 1'b0;
                cnt_next    = FIRST_LOAD;
                state_next  = ST_SEND;
            end

            ST_SEND: begin
                if (clk_fall) begin
                    cnt_next     = BIT_LOAD;
                    bit_cnt_next = bit_cnt_reg + 4'd1;
                    if (bit_cnt_reg == LAST_BIT_FALL) begin
                        state_next = ST_ACK;
                    end else begin
                        data_oe_next = ~shift_reg[0];
                        shift_next   = {1'b0, shift_reg[9:1]};
                    end
                end else if (cnt_reg == '0) begin
                    clk_oe_next   = 1'b0;
                    data_oe_next  = 1'b0;
                    busy_next     = 1'b0;
                    err_next      = 1'b1;
                    err_code_next = (bit_cnt_reg == '0) ? ERR_FIRST : ERR_BIT;
                    state_next    = ST_FAIL;
                end else begin
                    cnt_next = cnt_reg - CNT_ONE;
                end
            end

            ST_ACK: begin
                cnt_next = BIT_LOAD;
                if (!data_sync) begin
                    state_next = ST_WAIT_IDLE;
                end else begin
                    clk_oe_next   = 1'b0;
                    data_oe_next  = 1'b0;
                    busy_next     = 1'b0;
                    err_next      = 1'b1;
                    err_code_next = ERR_NACK;
                    state_next    = ST_FAIL;
                end
            end

            ST_WAIT_IDLE: begin
                if (clk_sync && data_sync) begin
                    busy_next  = 1'b0;
                    done_next  = 1'b1;
                    state_next = ST_IDLE;
                end else if (cnt_reg == '0) begin
                    clk_oe_next   = 1'b0;
                    data_oe_next  = 1'b0;
                    busy_next     = 1'b0;
                    err_next      = 1'b1;
                    err_code_next = ERR_BIT;
                    state_next    = ST_FAIL;
                end else begin
                    cnt_next = cnt_reg - CNT_ONE;
                end
            end

            ST_FAIL: begin
                clk_oe_next  = 1'b0;
                data_oe_next = 1'b0;
                state_next   = ST_IDLE;
            end

            default: begin
                clk_oe_next  = 1'b0;
                data_oe_next = 1'b0;
                busy_next    = 1'b0;
                state_next   = ST_IDLE;
            end
        endcase
    end

    assign ps2_clk_oe  = clk_oe_reg;
    assign ps2_data_oe = data_oe_reg;
    assign busy        = busy_reg;
    assign done        = done_reg;
    assign err         = err_reg;
    assign err_code    = err_code_reg;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a PS/2 device model drives the open-drain lines, and a
// per-cycle compare process checks busy/pulse/err_code against a frame-level model.
`timescale 1ns/1ps
module tb_ps2_host_tx;

    localparam int CLK_HZ      = 1_000_000;
    localparam int INHIBIT_CYC = 100;
    localparam int FIRST_CYC   = 15_000;
    localparam int BIT_CYC     = 2_000;
    localparam int HALF        = 20;

    localparam int M_ACK    = 0;
    localparam int M_NACK   = 1;
    localparam int M_SILENT = 2;
    localparam int M_STOP   = 3;
    localparam int M_RESET  = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       dev_clk_low = 1'b0;
    logic       dev_data_low = 1'b0;
    logic       ps2_clk_in, ps2_data_in;
    logic       ps2_clk_oe, ps2_data_oe, busy, done, err;
    logic [1:0] err_code;

    // Open-drain wired-AND of host and device pull-downs.
    assign ps2_clk_in  = ~(ps2_clk_oe | dev_clk_low);
    assign ps2_data_in = ~(ps2_data_oe | dev_data_low);

    ps2_host_tx #(
        .CLK_HZ        (CLK_HZ),
        .INHIBIT_US    (100),
        .FIRST_EDGE_US (15_000),
        .BIT_EDGE_US   (2_000)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .tx_data     (tx_data),
        .ps2_clk_in  (ps2_clk_in),
        .ps2_data_in (ps2_data_in),
        .ps2_clk_oe  (ps2_clk_oe),
        .ps2_data_oe (ps2_data_oe),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .err_code    (err_code)
    );

    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_pass = 0;
    int         cyc = 0;
    bit         mon_en = 1'b0;
    bit         exp_busy = 1'b0;
    bit         exp_is_err = 1'b0;
    logic [1:0] exp_code = 2'b00;
    logic [1:0] exp_err_code = 2'b00;
    bit         seen_done = 1'b0;
    bit         seen_err = 1'b0;
    int         pulse_cyc = 0;
    logic [10:0] last_got;

    task automatic check(input bit ok, input string name, input int act, input int req);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    endtask

    // Frame on the wire: start 0, data LSB first, odd parity, stop 1.
    function automatic logic [10:0] model_frame(input logic [7:0] b);
        logic [10:0] f;
        int ones;
        ones = 0;
        f = '0;
        for (int k = 0; k < 8; k++) begin
            ones += int'(b[k]);
            f[k + 1] = b[k];
        end
        f[9]  = ((ones % 2) == 0);
        f[10] = 1'b1;
        return f;
    endfunction

    // Per-cycle compare against the frame-level model.
    always @(negedge clk) begin
        cyc++;
        if (mon_en) begin
            if (done || err) begin
                check(exp_busy, "pulse_outside_frame", int'(done | err), 0);
                check(!busy, "busy_low_at_pulse", int'(busy), 0);
                check(!(done && err), "done_err_exclusive", int'(done & err), 0);
                if (done) begin
                    check(!exp_is_err, "done_vs_expected_err", 1, 0);
                    seen_done = 1'b1;
                end
                if (err) begin
                    check(exp_is_err, "err_vs_expected_done", 1, 0);
                    seen_err = 1'b1;
                    exp_code = exp_err_code;
                end
                pulse_cyc = cyc;
                exp_busy = 1'b0;
            end else if (exp_busy) begin
                check(busy, "busy_during_frame", int'(busy), 1);
            end else begin
                check(!busy, "busy_when_idle", int'(busy), 0);
                check(!ps2_clk_oe && !ps2_data_oe, "enables_when_idle",
                      int'({ps2_clk_oe, ps2_data_oe}), 0);
            end
            check(err_code == exp_code, "err_code", int'(err_code), int'(exp_code));
        end
        if (rst) begin
            exp_busy = 1'b0;
            exp_code = 2'b00;
        end else if (start && !exp_busy) begin
            exp_busy = 1'b1;
            exp_code = 2'b00;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_pulse(input int budget);
        for (int t = 0; t < budget && !seen_done && !seen_err; t++) step();
    endtask

    task automatic run_frame(input logic [7:0] b, input int mode, input int stop_n, input bit stray);
        logic [10:0] want, got, mask;
        int  hi, fall_cyc, release_cyc, nfall;
        bit  prev_oe, aborted;
        want = model_frame(b);
        got = '0;
        mask = 11'h001;
        aborted = 1'b0;
        nfall = 0;
        exp_is_err = (mode == M_NACK || mode == M_SILENT || mode == M_STOP);
        exp_err_code = (mode == M_SILENT) ? 2'b01 : (mode == M_STOP) ? 2'b10 :
                       (mode == M_NACK) ? 2'b11 : 2'b00;
        seen_done = 1'b0;
        seen_err = 1'b0;

        tx_data = b;
        start = 1'b1;
        step();
        start = 1'b0;
        tx_data = ~b;
        check(busy && ps2_clk_oe, "busy_clk_oe_rise", int'({busy, ps2_clk_oe}), 3);

        hi = 0;
        while (ps2_clk_oe && hi < 1000) begin
            if (hi == INHIBIT_CYC / 2)
                check(!ps2_data_oe, "data_oe_low_mid_inhibit", int'(ps2_data_oe), 0);
            hi++;
            step();
        end
        check(hi >= INHIBIT_CYC && hi <= INHIBIT_CYC + 1, "inhibit_length", hi, INHIBIT_CYC);
        got[0] = ps2_data_in;
        release_cyc = cyc;
        fall_cyc = cyc;

        if (mode == M_SILENT) begin
            wait_pulse(FIRST_CYC + 100);
            check(seen_err && (pulse_cyc - release_cyc) >= FIRST_CYC &&
                  (pulse_cyc - release_cyc) <= FIRST_CYC + 4,
                  "first_edge_timeout", pulse_cyc - release_cyc, FIRST_CYC);
            check(!ps2_clk_oe && !ps2_data_oe, "enables_after_err",
                  int'({ps2_clk_oe, ps2_data_oe}), 0);
        end else begin
            for (int i = 1; i <= 11; i++) begin
                if (mode == M_STOP && i > stop_n) break;
                repeat (HALF) step();
                if (i == 11 && mode != M_NACK) dev_data_low = 1'b1;
                dev_clk_low = 1'b1;
                fall_cyc = cyc;
                nfall = i;
                prev_oe = ps2_data_oe;
                step();
                step();
                if (i <= 10) check(ps2_data_oe == prev_oe, "data_oe_before_latency",
                                   int'(ps2_data_oe), int'(prev_oe));
                step();
                if (i <= 10) check(ps2_data_oe == !want[i], "data_oe_3_after_fall",
                                   int'(ps2_data_oe), int'(!want[i]));
                if (mode == M_RESET && i == stop_n) begin
                    rst = 1'b1;
                    step();
                    rst = 1'b0;
                    dev_clk_low = 1'b0;
                    dev_data_low = 1'b0;
                    check(!busy && !ps2_clk_oe && !ps2_data_oe && !done && !err && err_code == 2'b00,
                          "reset_mid_frame",
                          int'({busy, ps2_clk_oe, ps2_data_oe, done, err, err_code}), 0);
                    aborted = 1'b1;
                    break;
                end
                if (stray && i == 3) begin
                    tx_data = ~b;
                    start = 1'b1;
                    step();
                    start = 1'b0;
                    repeat (HALF - 4) step();
                end else begin
                    repeat (HALF - 3) step();
                end
                dev_clk_low = 1'b0;
                if (i <= 10) begin
                    got[i] = ps2_data_in;
                    mask[i] = 1'b1;
                end else begin
                    dev_data_low = 1'b0;
                end
            end

            if (aborted) begin
                repeat (50) step();
                check(!seen_done && !seen_err, "no_pulse_after_reset",
                      int'({seen_done, seen_err}), 0);
            end else if (mode == M_STOP) begin
                wait_pulse(BIT_CYC + 100);
                check(seen_err && (pulse_cyc - fall_cyc) >= BIT_CYC &&
                      (pulse_cyc - fall_cyc) <= BIT_CYC + 6,
                      "bit_timeout", pulse_cyc - fall_cyc, BIT_CYC);
            end else begin
                wait_pulse(200);
                if (mode == M_ACK) check(seen_done && !seen_err, "ack_gives_done",
                                         int'({seen_done, seen_err}), 2);
                else check(seen_err && !seen_done, "nack_gives_err",
                           int'({seen_done, seen_err}), 1);
            end
        end
        check(((got ^ want) & mask) == 11'h000, "wire_frame", int'(got), int'(want));
        $display("tx byte=%02h mode=%0d falls=%0d wire=%03h done=%0d err=%0d err_code=%0d",
                 b, mode, nfall, got, seen_done, seen_err, err_code);
        last_got = got;
        repeat (10) step();
    endtask

    initial begin
        #(1_500_000);
        $display("FAIL watchdog: simulation exceeded its cycle budget");
        $fatal(1, "watchdog");
    end

    initial begin
        int sel;
        logic [7:0] rb;
        repeat (3) step();
        check(ps2_clk_oe == 1'b0, "reset_clk_oe", int'(ps2_clk_oe), 0);
        check(ps2_data_oe == 1'b0, "reset_data_oe", int'(ps2_data_oe), 0);
        check(busy == 1'b0, "reset_busy", int'(busy), 0);
        check(done == 1'b0, "reset_done", int'(done), 0);
        check(err == 1'b0, "reset_err", int'(err), 0);
        check(err_code == 2'b00, "reset_err_code", int'(err_code), 0);
        rst = 1'b0;
        mon_en = 1'b1;
        check(model_frame(8'hF4) == 11'h5E8, "model_frame_f4", int'(model_frame(8'hF4)), 'h5E8);
        check(model_frame(8'hFF) == 11'h7FE, "model_frame_ff", int'(model_frame(8'hFF)), 'h7FE);
        repeat (5) step();

        run_frame(8'hF4, M_ACK, 0, 1'b0);
        check(last_got == 11'h5E8, "wire_f4_literal", int'(last_got), 'h5E8);
        run_frame(8'hFF, M_ACK, 0, 1'b1);
        check(last_got == 11'h7FE, "wire_ff_literal", int'(last_got), 'h7FE);
        run_frame(8'h5A, M_SILENT, 0, 1'b0);
        check(err_code == 2'b01, "hold_err_first", int'(err_code), 1);
        run_frame(8'hED, M_STOP, 4, 1'b0);
        check(err_code == 2'b10, "hold_err_bit", int'(err_code), 2);
        run_frame(8'hF3, M_NACK, 0, 1'b0);
        check(err_code == 2'b11, "hold_err_nack", int'(err_code), 3);
        run_frame(8'hA7, M_RESET, 5, 1'b1);
        run_frame(8'h3C, M_ACK, 0, 1'b0);

        for (int r = 0; r < 16; r++) begin
            rb = 8'($urandom);
            sel = $urandom_range(0, 9);
            if (sel <= 5) run_frame(rb, M_ACK, 0, sel[0]);
            else if (sel <= 7) run_frame(rb, M_NACK, 0, 1'b0);
            else run_frame(rb, M_STOP, $urandom_range(1, 10), 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/ps2_host_tx.md
# ps2_host_tx

Host-to-device PS/2 transmitter for the UP2 board. It sends one command byte, such as reset (0xFF) or enable reporting (0xF4), to the keyboard or mouse on PS2_CLK/PS2_DATA or FLEX_MOUSE_CLK/FLEX_MOUSE_DATA. It is the outbound counterpart of the PS/2 receive path. It drives only open-drain enables; the top level turns each enable into `1'b0 : 1'bz` on the inout pin and feeds the pin back as an input.

## Interface
- CLK_HZ, 25_175_000: frequency of clk in Hz; all time constants derive from it.
- INHIBIT_US, 100: time the host holds clock low before the request-to-send.
- FIRST_EDGE_US, 15_000: maximum wait from clock release to the device's first falling clock edge.
- BIT_EDGE_US, 2_000: maximum gap between any two later falling clock edges.
- clk  in  1  system clock (MCLK at top level).
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request; accepted only when busy=0.
- tx_data  in  8  command byte, captured on the cycle start is accepted.
- ps2_clk_in  in  1  raw clock pin readback, asynchronous.
- ps2_data_in  in  1  raw data pin readback, asynchronous.
- ps2_clk_oe  out  1  1 = pull clock low.
- ps2_data_oe  out  1  1 = pull data low.
- busy  out  1  high from the accepted start until done or err.
- done  out  1  one-cycle pulse when the device acknowledged the byte.
- err  out  1  one-cycle pulse on failure.
- err_code  out  2  01 = first-edge timeout, 10 = bit timeout, 11 = no ack; holds until the next accepted start.

## Operation
- Both pins pass through a 2-FF synchronizer. A falling edge (fall) is detected from the synchronized clock against its previous value.
- The shift register holds {stop=1, odd parity, tx_data[7:0]}. Parity is the XNOR-reduction of tx_data, so 0xFF gives parity 1 and 0xF4 gives parity 0.
- States:
  - IDLE: clk_oe=0 and data_oe=0. An accepted start captures the byte, sets busy and goes to INHIBIT.
  - INHIBIT: clk_oe=1 for INHIBIT_CYC = CLK_HZ/1_000_000*INHIBIT_US cycles. On the last cycle data_oe is set to 1, which is the start bit. Then go to REQ.
  - REQ: one cycle with clk_oe=1 and data_oe=1. Next cycle clk_oe=0, data_oe stays 1, the timeout counter loads FIRST_EDGE_CYC, then go to SEND.
  - SEND: on each fall, set data_oe = ~shift[0], shift right, increment bit_cnt and reload the timeout counter with BIT_EDGE_CYC. On the fall that presents the stop bit (10th fall), data_oe becomes 0. The 11th fall moves to ACK.
  - ACK: on entry, sample the synchronized data. Low means ack and goes to WAIT_IDLE. High means err_code=11 and goes to FAIL.
  - WAIT_IDLE: wait until synchronized clock and data are both high, then pulse done, clear busy and return to IDLE. This wait is also bounded by BIT_EDGE_CYC; expiry gives err_code=10.
  - FAIL: both enables 0, pulse err, clear busy, then IDLE.
- Timeout counter expiry in SEND: err_code=01 if no fall has been seen yet, else 10. Go to FAIL.
- start while busy=1 is ignored; tx_data is not re-captured.
- rst in any state: next cycle both enables 0, busy/done/err 0, err_code 00, state IDLE. The bus is released even mid-frame.

## Timing
- Reset values: ps2_clk_oe=0, ps2_data_oe=0, busy=0, done=0, err=0, err_code=00.
- busy rises the cycle after start is accepted. clk_oe rises on that same cycle.
- Pin fall to data_oe change: 3 clk cycles (two synchronizer stages plus the edge register). This is far below the device's ~30 µs half-period.
- done and err are each exactly 1 cycle wide and mutually exclusive. busy falls on the same edge that done or err rises.
- The timeout counter is wide enough for FIRST_EDGE_CYC: $clog2(CLK_HZ/1000*15)+1 bits.

## Structure
- Package ps2_pkg holds the state enum, the err_code constants (ERR_NONE, ERR_FIRST, ERR_BIT, ERR_NACK) and the cycle-count functions derived from CLK_HZ.
- Sub-module ps2_line_sync contains the 2-FF synchronizer for clock and data plus the fall detector. It is reusable by the receive path.

## Test plan
All scenarios use CLK_HZ=1_000_000 (1 µs per cycle). The bench device model clocks at 40 µs per bit and samples data on rising edges.

- Send 0xF4 -> clk_oe low for 100 cycles; device sees start 0, data bits LSB-first 0,0,1,0,1,1,1,1, parity 0, stop 1; device acks -> done pulse, err_code=00.
- Send 0xFF -> parity bit 1 on wire; done asserted; busy high for the whole frame and low the same cycle done rises.
- Device never clocks after request -> err with err_code=01 at 15_000 cycles after clock release; both enables 0.
- Device stops after 4 edges -> err with err_code=10, 2_000 cycles after the 4th fall.
- Device leaves data high at the ack edge -> err with err_code=11 and no done.
- rst asserted during bit 5, and start pulsed while busy -> rst releases both enables the next cycle and returns to IDLE with busy=0; the second start is ignored with tx_data unchanged on the wire.
